// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the arbiter FSM states and the frame/timeout defaults.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_START    = 2'd1,
        ST_WAIT_ACT = 2'd2,
        ST_WAIT_END = 2'd3
    } arb_state_t;

    localparam int UART_FRAME_BITS   = 11;
    localparam int START_TIMEOUT_DEF = 15;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side valid/ready bundle for the UART transmit arbiter.
// Sources drive through master, the arbiter consumes through slave.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit
// at or above ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any
);

    // Walk offsets from far to near so the nearest hit wins.
    always_comb begin
        gnt_id = ptr;
        any    = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_REQ]) begin
                gnt_id = ID_W'((int'(ptr) + i) % NUM_REQ);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between
// NUM_REQ byte sources; tracks each frame to completion or timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_arbiter_if.slave req,
    output logic            tx_start,
    output logic [7:0]      tx_data,
    input  logic            tx_active,
    output logic [ID_W-1:0] grant_id,
    output logic            busy,
    output logic            sent_valid,
    output logic            err_timeout
);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [7:0]         CNT_LAST = 8'(START_TIMEOUT - 1);

    arb_state_t      state;
    logic [ID_W-1:0] rr_ptr;
    logic [7:0]      cnt;
    logic [ID_W-1:0] pick_id;
    logic            pick_any;
    logic [ID_W-1:0] nxt_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req.req_valid),
        .ptr    (rr_ptr),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    assign nxt_ptr = (pick_id == ID_W'(NUM_REQ - 1))
                   ? '0 : pick_id + ID_W'(1);

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            cnt           <= '0;
            tx_start      <= 1'b0;
            tx_data       <= '0;
            grant_id      <= '0;
            sent_valid    <= 1'b0;
            err_timeout   <= 1'b0;
            req.req_ready <= '0;
        end else begin
            tx_start      <= 1'b0;
            sent_valid    <= 1'b0;
            err_timeout   <= 1'b0;
            req.req_ready <= '0;
            case (state)
                ST_IDLE: begin
                    // Hold off while tx is still draining a frame.
                    if (!tx_active && pick_any) begin
                        tx_data       <= req.req_data[{pick_id, 3'b000} +: 8];
                        grant_id      <= pick_id;
                        req.req_ready <= ONE_HOT0 << pick_id;
                        tx_start      <= 1'b1;
                        rr_ptr        <= nxt_ptr;
                        state         <= ST_START;
                    end
                end
                ST_START: begin
                    cnt   <= '0;
                    state <= ST_WAIT_ACT;
                end
                ST_WAIT_ACT: begin
                    if (tx_active) begin
                        state <= ST_WAIT_END;
                    end else if (cnt == CNT_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_WAIT_END: begin
                    if (!tx_active) begin
                        sent_valid <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural tx model
// and a queue of expected (owner, byte) frames.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N         = 4;
    localparam int IW        = 2;
    localparam int CPB       = 2;
    localparam int FRAME_CYC = UART_FRAME_BITS * CPB + 1;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [7:0]    data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_active;
    logic [IW-1:0] grant_id;
    logic          busy;
    logic          sent_valid;
    logic          err_timeout;

    logic          stall = 1'b0;
    logic          pend;
    int            tcnt;
    logic [7:0]    cap;

    exp_t          sb[$];
    int            rem[N];
    int            ready2_n = 0;
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) rq();

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .ID_W          (IW),
        .START_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (rq),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_active   (tx_active),
        .grant_id    (grant_id),
        .busy        (busy),
        .sent_valid  (sent_valid),
        .err_timeout (err_timeout)
    );

    // Transmitter stand-in: goes active two edges after the strobe.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_active <= 1'b0;
            tcnt      <= 0;
            pend      <= 1'b0;
            cap       <= 8'h00;
        end else begin
            pend <= tx_start && !stall;
            if (tx_start) cap <= tx_data;
            if (pend) begin
                tx_active <= 1'b1;
                tcnt      <= FRAME_CYC;
            end else if (tcnt > 1) begin
                tcnt <= tcnt - 1;
            end else if (tcnt == 1) begin
                tcnt      <= 0;
                tx_active <= 1'b0;
            end
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = IW'(id);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic request(input int i, input logic [7:0] d, input int n);
        rem[i] = n;
        rq.req_data[8*i +: 8] = d;
        rq.req_valid[i] = 1'b1;
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (rq.req_ready[i]) begin
                if (i == 2) ready2_n++;
                if (rem[i] > 0) rem[i]--;
                if (rem[i] == 0) rq.req_valid[i] = 1'b0;
            end
        end
        if (sent_valid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_sent", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sent_id", 32'(grant_id), 32'(e.id));
                check("sent_data", 32'(tx_data), 32'(e.data));
                check("line_data", 32'(cap), 32'(e.data));
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            cycle();
            n++;
        end
        check("idle_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_sent(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!sent_valid && n < budget);
        check("sent_budget", 32'(sent_valid), 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_start"}, 32'(tx_start), 32'd0);
        check({tag, "_ready"}, 32'(rq.req_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sent"}, 32'(sent_valid), 32'd0);
        check({tag, "_err"}, 32'(err_timeout), 32'd0);
        check({tag, "_gid"}, 32'(grant_id), 32'd0);
        check({tag, "_data"}, 32'(tx_data), 32'd0);
    endtask

    initial begin
        int n;
        rq.req_valid = '0;
        rq.req_data  = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;

        // Reset state
        repeat (3) cycle();
        check_quiet("rst");
        reset = 1'b1;

        // 1: single request
        request(0, 8'hA5, 1);
        push(0, 8'hA5);
        cycle();
        check("t1_ready", 32'(rq.req_ready), 32'h1);
        check("t1_start", 32'(tx_start), 32'd1);
        check("t1_data", 32'(tx_data), 32'hA5);
        wait_idle(200);
        check("t1_parity", 32'(^cap), 32'd0);

        // 2: all four, id 0 holds for a second byte
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        request(0, 8'h11, 2);
        request(1, 8'h22, 1);
        request(2, 8'h33, 1);
        request(3, 8'h44, 1);
        push(0, 8'h11);
        push(1, 8'h22);
        push(2, 8'h33);
        push(3, 8'h44);
        push(0, 8'h11);
        for (int f = 0; f < 4; f++) begin
            wait_sent(200);
            cycle();
            check("t2_gap_start", 32'(tx_start), 32'd1);
        end
        wait_idle(200);

        // 3: pointer fairness after granting id 2
        request(2, 8'h5C, 1);
        push(2, 8'h5C);
        wait_idle(200);
        request(1, 8'h61, 1);
        request(3, 8'h63, 1);
        push(3, 8'h63);
        push(1, 8'h61);
        cycle();
        check("t3_first", 32'(rq.req_ready), 32'h8);
        wait_idle(300);

        // 4: stalled transmitter
        stall = 1'b1;
        request(0, 8'h77, 1);
        cycle();
        check("t4_start", 32'(tx_start), 32'd1);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!err_timeout && n < 40);
        check("t4_latency", 32'(n), 32'd16);
        check("t4_busy", 32'(busy), 32'd0);
        stall = 1'b0;
        repeat (3) cycle();

        // 5: reset during a data bit
        request(0, 8'h3C, 1);
        cycle();
        check("t5_start", 32'(tx_start), 32'd1);
        repeat (11) cycle();
        check("t5_mid_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1 check_quiet("t5_async");
        repeat (3) cycle();
        reset = 1'b1;
        repeat (2) cycle();
        request(1, 8'h96, 1);
        push(1, 8'h96);
        cycle();
        check("t5_gid", 32'(grant_id), 32'd1);
        check("t5_ready", 32'(rq.req_ready), 32'h2);
        wait_idle(200);

        // 6: id 2 withdraws while id 0 is served
        ready2_n = 0;
        request(0, 8'hC3, 1);
        push(0, 8'hC3);
        cycle();
        check("t6_ready", 32'(rq.req_ready), 32'h1);
        repeat (3) cycle();
        request(2, 8'hEE, 1);
        repeat (5) cycle();
        rq.req_valid[2] = 1'b0;
        rem[2] = 0;
        wait_idle(200);
        repeat (5) cycle();
        check("t6_no_ready2", 32'(ready2_n), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
